method_array_server: RTL and testbench

//  Method-call responder: exposes an on-chip word array through set/get/sum/clear

---
 rtl/method_array_server_pkg.sv | 25 ++
 rtl/method_array_server_ram.sv | 23 ++
 rtl/method_array_server.sv | 245 ++++++++++++++++++++++++
 tb/tb_method_array_server.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/method_array_server_pkg.sv
// method_array_server_pkg: FSM state encodings, method-select codes and the index range helper
// shared by the method_array_server slice.
package method_array_server_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SET_WR   = 3'd1;
  localparam logic [2:0] S_GET_RD   = 3'd2;
  localparam logic [2:0] S_GET_WAIT = 3'd3;
  localparam logic [2:0] S_SUM_RD   = 3'd4;
  localparam logic [2:0] S_SUM_ACC  = 3'd5;
  localparam logic [2:0] S_CLR_WR   = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  typedef enum logic [1:0] {
    M_SET = 2'd0,
    M_GET = 2'd1,
    M_SUM = 2'd2,
    M_CLR = 2'd3
  } method_e;

  function automatic logic inRange(input logic [31:0] idx, input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/method_array_server_ram.sv
// method_array_ram: single-port DEPTH x WIDTH storage with registered read; a read during a
// write returns the old word.
module method_array_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= din_i;
    if (re_i) dout_o <= mem[addr_i];
  end

endmodule

// File: rtl/method_array_server.sv
// method_array_server: set/get/sum/clear method responder over an on-chip word array plus a
// direct a_* port. Define SUM_SAT_EN for a saturating sum with the sum_ovf flag.
module method_array_server
  import method_array_server_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    a_address,
  input  logic             a_we,
  input  logic             a_oe,
  input  logic [WIDTH-1:0] a_din,
  output logic [WIDTH-1:0] a_dout,
  output logic [31:0]      a_length,
  input  logic [AW-1:0]    set_i,
  input  logic [WIDTH-1:0] set_v,
  input  logic             set_req,
  output logic             set_busy,
  input  logic [AW-1:0]    get_i,
  input  logic             get_req,
  output logic             get_busy,
  output logic [WIDTH-1:0] get_return,
  input  logic             sum_req,
  output logic             sum_busy,
  output logic [WIDTH-1:0] sum_return,
  input  logic             clear_req,
`ifdef SUM_SAT_EN
  output logic             sum_ovf,
`endif
  output logic             clear_busy
);

  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAW-1:0] LAST_IDX = RAW'(DEPTH - 1);

  logic [2:0]       state_q, state_d;
  method_e          method_q, method_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [RAW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q;
  logic             rdValid1_q, rdValid2_q;
  logic [WIDTH-1:0] getRet_q, getRet_d;
  logic [WIDTH-1:0] sumRet_q, sumRet_d;
  logic             dirRd_q, dirRd_d;
  logic             dirOor_q;
  logic [WIDTH-1:0] aHold_q;
  logic [WIDTH-1:0] dirData;

  logic             ramWe, ramRe;
  logic [RAW-1:0]   ramAddr;
  logic [WIDTH-1:0] ramDin, ramDout;
  logic             idxOk, aAddrOk;

`ifdef SUM_SAT_EN
  logic             ovf_q, ovf_d;
  logic             sumOvf_q, sumOvf_d;
  logic [WIDTH:0]   sumExt;
`endif

  assign idxOk   = inRange(32'(idx_q), DEPTH);
  assign aAddrOk = inRange(32'(a_address), DEPTH);

  // FSM, arbitration and RAM port steering; the direct port only gets the RAM on idle cycles
  // where no method is accepted.
  always_comb begin
    state_d  = state_q;
    method_d = method_q;
    idx_d    = idx_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    getRet_d = getRet_q;
    sumRet_d = sumRet_q;
    dirRd_d  = 1'b0;
    ramWe    = 1'b0;
    ramRe    = 1'b0;
    ramAddr  = '0;
    ramDin   = '0;
`ifdef SUM_SAT_EN
    ovf_d    = ovf_q;
    sumOvf_d = sumOvf_q;
    sumExt   = '0;
`endif

    if (rdValid2_q) begin
`ifdef SUM_SAT_EN
      sumExt = {1'b0, acc_q} + {1'b0, data_q};
      if (sumExt[WIDTH] || ovf_q) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sumExt[WIDTH-1:0];
      end
`else
      acc_d = acc_q + data_q;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (set_req) begin
          method_d = M_SET;
          idx_d    = set_i;
          val_d    = set_v;
          state_d  = S_SET_WR;
        end else if (get_req) begin
          method_d = M_GET;
          idx_d    = get_i;
          state_d  = S_GET_RD;
        end else if (sum_req) begin
          method_d = M_SUM;
          cnt_d    = '0;
          acc_d    = '0;
`ifdef SUM_SAT_EN
          ovf_d    = 1'b0;
`endif
          state_d  = S_SUM_RD;
        end else if (clear_req) begin
          method_d = M_CLR;
          cnt_d    = '0;
          state_d  = S_CLR_WR;
        end else begin
          ramAddr = a_address[RAW-1:0];
          ramDin  = a_din;
          ramWe   = a_we && aAddrOk;
          ramRe   = a_oe && aAddrOk;
          dirRd_d = a_oe;
        end
      end
      S_SET_WR: begin
        ramWe   = idxOk;
        ramAddr = idx_q[RAW-1:0];
        ramDin  = val_q;
        state_d = S_DONE;
      end
      S_GET_RD: begin
        ramRe   = idxOk;
        ramAddr = idx_q[RAW-1:0];
        state_d = S_GET_WAIT;
      end
      S_GET_WAIT: state_d = S_DONE;
      S_SUM_RD: begin
        ramRe   = 1'b1;
        ramAddr = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_SUM_ACC;
      end
      S_SUM_ACC: begin
        if (!rdValid1_q) state_d = S_DONE;
      end
      S_CLR_WR: begin
        ramWe   = 1'b1;
        ramAddr = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (method_q == M_GET) getRet_d = idxOk ? data_q : '0;
        if (method_q == M_SUM) begin
          sumRet_d = acc_q;
`ifdef SUM_SAT_EN
          sumOvf_d = ovf_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is staged through data_q before the adder so the sum path stays register to register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      method_q   <= M_SET;
      idx_q      <= '0;
      val_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      rdValid1_q <= 1'b0;
      rdValid2_q <= 1'b0;
      getRet_q   <= '0;
      sumRet_q   <= '0;
      dirRd_q    <= 1'b0;
      dirOor_q   <= 1'b0;
      aHold_q    <= '0;
`ifdef SUM_SAT_EN
      ovf_q      <= 1'b0;
      sumOvf_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      method_q   <= method_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_q     <= ramDout;
      rdValid1_q <= (state_q == S_SUM_RD);
      rdValid2_q <= rdValid1_q;
      getRet_q   <= getRet_d;
      sumRet_q   <= sumRet_d;
      dirRd_q    <= dirRd_d;
      dirOor_q   <= !aAddrOk;
      if (dirRd_q) aHold_q <= dirData;
`ifdef SUM_SAT_EN
      ovf_q      <= ovf_d;
      sumOvf_q   <= sumOvf_d;
`endif
    end
  end

  method_array_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (RAW)
  ) u_ram (
    .clk_i (clk),
    .we_i  (ramWe),
    .re_i  (ramRe),
    .addr_i(ramAddr),
    .din_i (ramDin),
    .dout_o(ramDout)
  );

  assign dirData    = dirOor_q ? '0 : ramDout;
  assign a_dout     = dirRd_q ? dirData : aHold_q;
  assign a_length   = 32'(DEPTH);
  assign get_return = getRet_q;
  assign sum_return = sumRet_q;
  assign set_busy   = (state_q != S_IDLE) && (method_q == M_SET);
  assign get_busy   = (state_q != S_IDLE) && (method_q == M_GET);
  assign sum_busy   = (state_q != S_IDLE) && (method_q == M_SUM);
  assign clear_busy = (state_q != S_IDLE) && (method_q == M_CLR);
`ifdef SUM_SAT_EN
  assign sum_ovf    = sumOvf_q;
`endif

endmodule

// File: tb/tb_method_array_server.sv
// tb_method_array_server: directed bench for method_array_server (DEPTH=16, AW=5 build);
// SUM_SAT_EN selects the saturating-sum expectations.
module tb_method_array_server;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a_address;
  logic        a_we, a_oe;
  logic [31:0] a_din, a_dout, a_length;
  logic [4:0]  set_i, get_i;
  logic [31:0] set_v;
  logic        set_req, set_busy, get_req, get_busy, sum_req, sum_busy, clear_req, clear_busy;
  logic [31:0] get_return, sum_return;
`ifdef SUM_SAT_EN
  logic        sum_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  method_array_server #(
    .WIDTH(32),
    .DEPTH(16),
    .AW   (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_address (a_address),
    .a_we      (a_we),
    .a_oe      (a_oe),
    .a_din     (a_din),
    .a_dout    (a_dout),
    .a_length  (a_length),
    .set_i     (set_i),
    .set_v     (set_v),
    .set_req   (set_req),
    .set_busy  (set_busy),
    .get_i     (get_i),
    .get_req   (get_req),
    .get_busy  (get_busy),
    .get_return(get_return),
    .sum_req   (sum_req),
    .sum_busy  (sum_busy),
    .sum_return(sum_return),
    .clear_req (clear_req),
`ifdef SUM_SAT_EN
    .sum_ovf   (sum_ovf),
`endif
    .clear_busy(clear_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busyOf(input int m);
    case (m)
      0:       return set_busy;
      1:       return get_busy;
      2:       return sum_busy;
      default: return clear_busy;
    endcase
  endfunction

  // m: 0 set, 1 get, 2 sum, 3 clear; lat counts edges from accept to busy low
  task automatic applyStimulus(input int m, input logic [4:0] idx, input logic [31:0] val,
                               output int latency);
    set_i     = idx;
    get_i     = idx;
    set_v     = val;
    set_req   = (m == 0);
    get_req   = (m == 1);
    sum_req   = (m == 2);
    clear_req = (m == 3);
    tick();
    set_req   = 1'b0;
    get_req   = 1'b0;
    sum_req   = 1'b0;
    clear_req = 1'b0;
    checkOutput("busyRise", 32'(busyOf(m)), 32'd1);
    latency = 0;
    while (busyOf(m) && latency < 200) begin
      tick();
      latency++;
    end
  endtask

  task automatic directWrite(input logic [4:0] addr, input logic [31:0] data);
    a_address = addr;
    a_din     = data;
    a_we      = 1'b1;
    tick();
    a_we      = 1'b0;
  endtask

  task automatic directRead(input logic [4:0] addr, input logic [31:0] expected, input string tag);
    a_address = addr;
    a_oe      = 1'b1;
    tick();
    a_oe      = 1'b0;
    checkOutput(tag, a_dout, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_address = '0; a_we = 1'b0; a_oe = 1'b0; a_din = '0;
    set_i = '0; set_v = '0; get_i = '0;
    set_req = 1'b0; get_req = 1'b0; sum_req = 1'b0; clear_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    checkOutput("rstSetBusy", 32'(set_busy), 32'd0);
    checkOutput("rstGetBusy", 32'(get_busy), 32'd0);
    checkOutput("rstSumBusy", 32'(sum_busy), 32'd0);
    checkOutput("rstClrBusy", 32'(clear_busy), 32'd0);
    checkOutput("rstGetRet", get_return, 32'd0);
    checkOutput("rstSumRet", sum_return, 32'd0);
    checkOutput("rstADout", a_dout, 32'd0);
    checkOutput("aLength", a_length, 32'd16);
`ifdef SUM_SAT_EN
    checkOutput("rstOvf", 32'(sum_ovf), 32'd0);
`endif

    applyStimulus(0, 5'd3, 32'h1234, lat);
    checkOutput("setLat", 32'(lat), 32'd2);
    applyStimulus(1, 5'd3, 32'h0, lat);
    checkOutput("getLat", 32'(lat), 32'd3);
    checkOutput("get3", get_return, 32'h1234);

    // simultaneous set and get: set wins, get stays pending
    set_i = 5'd5; set_v = 32'd7; get_i = 5'd5;
    set_req = 1'b1; get_req = 1'b1;
    tick();
    set_req = 1'b0;
    checkOutput("prioSetBusy", 32'(set_busy), 32'd1);
    checkOutput("prioGetIdle", 32'(get_busy), 32'd0);
    lat = 0;
    while (set_busy && lat < 200) begin tick(); lat++; end
    checkOutput("prioSetLat", 32'(lat), 32'd2);
    tick();
    get_req = 1'b0;
    checkOutput("pendGetBusy", 32'(get_busy), 32'd1);
    lat = 0;
    while (get_busy && lat < 200) begin tick(); lat++; end
    checkOutput("pendGetLat", 32'(lat), 32'd3);
    checkOutput("pendGet5", get_return, 32'd7);

    for (int k = 0; k < 16; k++) directWrite(5'(k), 32'(k + 1));
    directRead(5'd4, 32'd5, "aRead4");
    tick();
    checkOutput("aDoutHold", a_dout, 32'd5);
    applyStimulus(2, 5'd0, 32'h0, lat);
    checkOutput("sumLat", 32'(lat), 32'd19);
    checkOutput("sum136", sum_return, 32'd136);
`ifdef SUM_SAT_EN
    checkOutput("sumNoOvf", 32'(sum_ovf), 32'd0);
`endif

    for (int k = 0; k < 16; k++) directWrite(5'(k), (k < 2) ? 32'hFFFF_FFFF : 32'h0);
    applyStimulus(2, 5'd0, 32'h0, lat);
`ifdef SUM_SAT_EN
    checkOutput("sumSat", sum_return, 32'hFFFF_FFFF);
    checkOutput("sumOvf", 32'(sum_ovf), 32'd1);
`else
    checkOutput("sumWrap", sum_return, 32'hFFFF_FFFE);
`endif

    applyStimulus(3, 5'd0, 32'h0, lat);
    checkOutput("clrLat", 32'(lat), 32'd17);
    applyStimulus(1, 5'd3, 32'h0, lat);
    checkOutput("clrGet3", get_return, 32'd0);
    applyStimulus(1, 5'd0, 32'h0, lat);
    checkOutput("clrGet0", get_return, 32'd0);

    applyStimulus(0, 5'd3, 32'h55, lat);
    applyStimulus(1, 5'd3, 32'h0, lat);
    checkOutput("get3After", get_return, 32'h55);
    applyStimulus(1, 5'd20, 32'h0, lat);
    checkOutput("getOorLat", 32'(lat), 32'd3);
    checkOutput("getOor", get_return, 32'd0);
    applyStimulus(0, 5'd20, 32'hDEAD, lat);
    checkOutput("setOorLat", 32'(lat), 32'd2);
    applyStimulus(1, 5'd4, 32'h0, lat);
    checkOutput("setOorNoAlias", get_return, 32'd0);
    applyStimulus(2, 5'd0, 32'h0, lat);
    checkOutput("sumAfterOor", sum_return, 32'h55);

    // method accept beats a direct write on the same edge
    set_i = 5'd7; set_v = 32'd1; set_req = 1'b1;
    a_address = 5'd7; a_din = 32'd2; a_we = 1'b1;
    tick();
    set_req = 1'b0; a_we = 1'b0;
    lat = 0;
    while (set_busy && lat < 200) begin tick(); lat++; end
    applyStimulus(1, 5'd7, 32'h0, lat);
    checkOutput("setBeatsDirect", get_return, 32'd1);

    // direct write while a method runs is dropped
    get_i = 5'd3; get_req = 1'b1;
    tick();
    get_req = 1'b0;
    a_address = 5'd6; a_din = 32'h99; a_we = 1'b1;
    tick();
    a_we = 1'b0;
    lat = 1;
    while (get_busy && lat < 200) begin tick(); lat++; end
    checkOutput("getDuringDirect", get_return, 32'h55);
    directRead(5'd6, 32'd0, "directDropped");

    // reset two cycles into a sum
    sum_req = 1'b1;
    tick();
    sum_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstSumBusy", 32'(sum_busy), 32'd0);
    checkOutput("midRstSumRet", sum_return, 32'd0);
    checkOutput("midRstGetRet", get_return, 32'd0);
`ifdef SUM_SAT_EN
    checkOutput("midRstOvf", 32'(sum_ovf), 32'd0);
`endif
    applyStimulus(1, 5'd7, 32'h0, lat);
    checkOutput("postRstGetLat", 32'(lat), 32'd3);
    checkOutput("postRstGet7", get_return, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
